// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding, iteration count and negation helpers.
package mul_div_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the mul/div datapath: shift-add multiply step or
// restoring trial-subtract divide step over the {acc_hi, acc_lo} pair.
module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         is_div,
    input  logic [N-1:0] acc_hi,
    input  logic [N-1:0] acc_lo,
    input  logic [N-1:0] operand_b,
    output logic [N-1:0] acc_hi_next,
    output logic [N-1:0] acc_lo_next
);

    logic [N:0] add_sum_s;
    logic [N:0] shifted_s;
    logic [N:0] trial_s;

    // Single iteration; a negative trial difference means the divisor did not fit
    always_comb begin
        add_sum_s = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : {(N+1){1'b0}});
        shifted_s = {acc_hi, acc_lo[N-1]};
        trial_s   = shifted_s - {1'b0, operand_b};
        if (is_div) begin
            if (trial_s[N]) begin
                acc_hi_next = shifted_s[N-1:0];
                acc_lo_next = {acc_lo[N-2:0], 1'b0};
            end else begin
                acc_hi_next = trial_s[N-1:0];
                acc_lo_next = {acc_lo[N-2:0], 1'b1};
            end
        end else begin
            acc_hi_next = add_sum_s[N:1];
            acc_lo_next = {add_sum_s[0], acc_lo[N-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: captures operands on start, runs 32
// single-bit iterations, applies the sign fix and presents a registered result.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Start_i,
    input  logic [2:0]   Funct3_i,
    input  logic [N-1:0] Rs1_Data_i,
    input  logic [N-1:0] Rs2_Data_i,
    output logic         Busy_o,
    output logic         Done_o,
    output logic [N-1:0] Result_o
);

    state_t             state_r, state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         funct3_r;
    logic               a_neg_r, b_neg_r, div_zero_r;
    logic [N-1:0]       rs1_r, b_mag_r, acc_hi_r, acc_lo_r;
    logic               busy_r, done_r;
    logic [N-1:0]       result_r;

    logic               a_signed_s, b_signed_s, a_neg_s, b_neg_s, last_iter_s;
    logic [N-1:0]       a_mag_s, b_mag_s, step_hi_s, step_lo_s;
    logic [2*N-1:0]     prod_s;
    logic [N-1:0]       quot_s, rem_s, fix_result_s;

    mul_div_step #(.N(N)) u_step (
        .is_div      (funct3_r[2]),
        .acc_hi      (acc_hi_r),
        .acc_lo      (acc_lo_r),
        .operand_b   (b_mag_r),
        .acc_hi_next (step_hi_s),
        .acc_lo_next (step_lo_s)
    );

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        last_iter_s  = (cnt_r == CNT_W'(ITER_COUNT - 1));
        case (state_r)
            ST_IDLE: if (Start_i) state_next_s = ST_CALC; else state_next_s = ST_IDLE;
            ST_CALC: if (last_iter_s) state_next_s = ST_FIX; else state_next_s = ST_CALC;
            ST_FIX:  state_next_s = ST_DONE;
            ST_DONE: if (Start_i) state_next_s = ST_CALC; else state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operand sign decode and unsigned magnitudes at capture time
    always_comb begin
        a_signed_s = (Funct3_i == F3_MULH) || (Funct3_i == F3_MULHSU) ||
                     (Funct3_i == F3_DIV)  || (Funct3_i == F3_REM);
        b_signed_s = (Funct3_i == F3_MULH) || (Funct3_i == F3_DIV) || (Funct3_i == F3_REM);
        a_neg_s    = a_signed_s && Rs1_Data_i[N-1];
        b_neg_s    = b_signed_s && Rs2_Data_i[N-1];
        a_mag_s    = a_neg_s ? neg32(Rs1_Data_i) : Rs1_Data_i;
        b_mag_s    = b_neg_s ? neg32(Rs2_Data_i) : Rs2_Data_i;
    end

    // Sign fix and result select; divide by zero bypasses the sign fix
    always_comb begin
        if (a_neg_r ^ b_neg_r) begin
            prod_s = neg64({acc_hi_r, acc_lo_r});
            quot_s = neg32(acc_lo_r);
        end else begin
            prod_s = {acc_hi_r, acc_lo_r};
            quot_s = acc_lo_r;
        end
        if (a_neg_r) rem_s = neg32(acc_hi_r); else rem_s = acc_hi_r;
        case (funct3_r)
            F3_MUL:                       fix_result_s = prod_s[N-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result_s = prod_s[2*N-1:N];
            F3_DIV, F3_DIVU:              fix_result_s = div_zero_r ? {N{1'b1}} : quot_s;
            F3_REM, F3_REMU:              fix_result_s = div_zero_r ? rs1_r : rem_s;
            default:                      fix_result_s = prod_s[N-1:0];
        endcase
    end

    // State, registered status outputs, capture, iteration and result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {N{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            funct3_r   <= 3'b000;
            a_neg_r    <= 1'b0;
            b_neg_r    <= 1'b0;
            div_zero_r <= 1'b0;
            rs1_r      <= {N{1'b0}};
            b_mag_r    <= {N{1'b0}};
            acc_hi_r   <= {N{1'b0}};
            acc_lo_r   <= {N{1'b0}};
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_CALC) || (state_next_s == ST_FIX);
            done_r  <= (state_next_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (Start_i) begin
                        funct3_r   <= Funct3_i;
                        a_neg_r    <= a_neg_s;
                        b_neg_r    <= b_neg_s;
                        div_zero_r <= Funct3_i[2] && (Rs2_Data_i == {N{1'b0}});
                        rs1_r      <= Rs1_Data_i;
                        b_mag_r    <= b_mag_s;
                        acc_hi_r   <= {N{1'b0}};
                        acc_lo_r   <= a_mag_s;
                        cnt_r      <= {CNT_W{1'b0}};
                    end
                end
                ST_CALC: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                end
                ST_FIX:  result_r <= fix_result_s;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign Busy_o   = busy_r;
    assign Done_o   = done_r;
    assign Result_o = result_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit: expected results are queued at
// start and popped when Done_o pulses; latency, Busy_o and reset behaviour checked.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    logic        clk = 1'b0;
    logic        reset, Start_i;
    logic [2:0]  Funct3_i;
    logic [31:0] Rs1_Data_i, Rs2_Data_i;
    logic        Busy_o, Done_o;
    logic [31:0] Result_o;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    mul_div_unit #(.N(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start_i    (Start_i),
        .Funct3_i   (Funct3_i),
        .Rs1_Data_i (Rs1_Data_i),
        .Rs2_Data_i (Rs2_Data_i),
        .Busy_o     (Busy_o),
        .Done_o     (Done_o),
        .Result_o   (Result_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start in cycle 0 and queue its expected result; returns in cycle 1.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        Funct3_i   = f3;
        Rs1_Data_i = a;
        Rs2_Data_i = b;
        Start_i    = 1'b1;
        exp_q.push_back(exp);
        tick();
        Start_i = 1'b0;
    endtask

    // Wait (bounded) for Done_o starting at cycle cyc0, check latency, Busy_o and result.
    task automatic finish_op(input string tag, input int cyc0, output int lat);
        int          cyc;
        logic        busy_ok;
        logic [31:0] exp;
        cyc     = cyc0;
        busy_ok = 1'b1;
        while (Done_o !== 1'b1 && cyc < 40) begin
            if (Busy_o !== 1'b1) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        lat = cyc;
        check32({tag, " latency"}, 32'(cyc), 32'd34);
        check32({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check32({tag, " busy_at_done"}, {31'd0, Busy_o}, 32'd0);
        if (exp_q.size() == 0) begin
            check32({tag, " queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check32({tag, " result"}, Result_o, exp);
        end
    endtask

    initial begin
        int lat, lat2, done_seen;
        reset      = 1'b1;
        Start_i    = 1'b0;
        Funct3_i   = 3'b000;
        Rs1_Data_i = 32'd0;
        Rs2_Data_i = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check32("reset busy", {31'd0, Busy_o}, 32'd0);
        check32("reset done", {31'd0, Done_o}, 32'd0);
        check32("reset result", Result_o, 32'd0);

        start_op(F3_MUL, 32'd7, 32'd6, 32'h0000002A);
        finish_op("mul_7x6", 1, lat);
        tick();
        check32("done_pulse_width", {31'd0, Done_o}, 32'd0);
        check32("result_hold", Result_o, 32'h0000002A);

        start_op(F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        finish_op("mulh_m1xm1", 1, lat);
        tick();
        start_op(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        finish_op("mulhu_max", 1, lat);
        tick();
        start_op(F3_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
        finish_op("mulhsu_m1x2", 1, lat);
        tick();
        start_op(F3_MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
        finish_op("mul_m3x5", 1, lat);
        tick();
        start_op(F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        finish_op("div_m7_2", 1, lat);
        tick();
        start_op(F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        finish_op("rem_m7_2", 1, lat);
        tick();
        start_op(F3_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
        finish_op("div_7_m2", 1, lat);
        tick();
        start_op(F3_REM, 32'd7, 32'hFFFFFFFE, 32'h00000001);
        finish_op("rem_7_m2", 1, lat);
        tick();
        start_op(F3_DIVU, 32'd100, 32'd7, 32'd14);
        finish_op("divu_100_7", 1, lat);
        tick();
        start_op(F3_REMU, 32'd100, 32'd7, 32'd2);
        finish_op("remu_100_7", 1, lat);
        tick();
        start_op(F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        finish_op("div_overflow", 1, lat);
        tick();
        start_op(F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        finish_op("rem_overflow", 1, lat);
        tick();
        start_op(F3_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF);
        finish_op("divu_by_zero", 1, lat);
        tick();
        start_op(F3_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB);
        finish_op("rem_by_zero", 1, lat);
        tick();

        // Start pulse with new operands in cycle 5 must be ignored
        start_op(F3_DIVU, 32'd100, 32'd7, 32'd14);
        repeat (4) tick();
        Funct3_i   = F3_MUL;
        Rs1_Data_i = 32'd3;
        Rs2_Data_i = 32'd3;
        Start_i    = 1'b1;
        tick();
        Start_i = 1'b0;
        finish_op("start_while_busy", 6, lat);
        tick();
        check32("no_queued_start", {31'd0, Busy_o}, 32'd0);

        // Back-to-back: second start in the DONE cycle
        start_op(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        finish_op("b2b_first", 1, lat);
        start_op(F3_REMU, 32'd100, 32'd7, 32'd2);
        finish_op("b2b_second", 1, lat2);
        check32("b2b_abs_cycle", 32'(lat + lat2), 32'd68);
        tick();

        // Reset sampled in cycle 10 of a DIV aborts it
        start_op(F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check32("abort busy", {31'd0, Busy_o}, 32'd0);
        check32("abort done", {31'd0, Done_o}, 32'd0);
        check32("abort result", Result_o, 32'd0);
        check32("abort state", 32'(dut.state_r), 32'(ST_IDLE));
        done_seen = 0;
        repeat (40) begin
            if (Done_o === 1'b1) done_seen++;
            tick();
        end
        check32("abort no_done", 32'(done_seen), 32'd0);

        // Reset and start in the same cycle: reset wins
        Funct3_i   = F3_MUL;
        Rs1_Data_i = 32'd2;
        Rs2_Data_i = 32'd2;
        Start_i    = 1'b1;
        reset      = 1'b1;
        tick();
        Start_i = 1'b0;
        reset   = 1'b0;
        check32("reset_vs_start busy", {31'd0, Busy_o}, 32'd0);
        tick();
        check32("reset_vs_start idle", {31'd0, Busy_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
